// File: rtl/primogen_collector.sv
// Sequencer and FWFT buffer behind primogen: issues one request at a time,
// queues each valid prime for a valid/ready consumer, and halts for good on overflow.
module primogen_collector #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int CW    = 32
)(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  output logic                   gen_go,
  input  logic                   gen_ready,
  input  logic                   gen_error,
  input  logic [WIDTH-1:0]       gen_res,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  input  logic                   out_ready,
  output logic [CW-1:0]          count,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, HALT} state_t;

  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             push, pop;

  assign push      = (state == WAIT_DONE) && gen_ready && !gen_error;
  assign out_valid = (level != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = mem[rd_ptr];

  // Issue only with a free slot, so the result in flight can always be pushed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gen_go   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      gen_go <= 1'b0;
      case (state)
        IDLE:
          if (enable && gen_ready && (level < FULL)) begin
            state  <= ISSUE;
            gen_go <= 1'b1;
          end
        ISSUE:     state <= WAIT_BUSY;
        WAIT_BUSY: if (!gen_ready) state <= WAIT_DONE;
        WAIT_DONE:
          if (gen_ready) begin
            if (gen_error) begin
              overflow <= 1'b1;
              state    <= HALT;
            end else begin
              state <= IDLE;
            end
          end
        HALT:      state <= HALT;
        default:   state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        count  <= count + CW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      level <= level + LW'(1);
      else if (!push && pop) level <= level - LW'(1);
    end
  end

  // Storage carries no reset; the head is only meaningful while out_valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= gen_res;
  end

endmodule

// File: doc/primogen_collector.md
Name: primogen_collector

Overview:
- Sequencer and buffer directly downstream of primogen.
- Issues one-cycle go requests to the generator and waits for each result.
- Captures each valid prime into a first-word-fall-through FIFO and presents it to a consumer over a valid/ready interface.
- Stops permanently when the generator reports overflow, so the consumer never sees a bogus value.

Parameters:
- WIDTH, 16: width of generator result and of out_data.
- DEPTH, 8: FIFO entries; must be a power of two, at least 2.
- CW, 32: width of the prime counter.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  permission to start new generator requests.
- gen_go  out  1  one-cycle request pulse to primogen.
- gen_ready  in  1  primogen idle/result-valid flag.
- gen_error  in  1  primogen overflow flag; sampled with the ready rising edge.
- gen_res  in  WIDTH  primogen result; sampled with the ready rising edge.
- out_valid  out  1  FIFO non-empty.
- out_data  out  WIDTH  FIFO head value.
- out_ready  in  1  consumer accepts the head this cycle.
- count  out  CW  number of primes pushed since reset.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky; generator reported error.

Behaviour:
- Reset (async assert, released on a clock edge):
  - state=IDLE; gen_go=0, out_valid=0, count=0, level=0, overflow=0.
  - FIFO pointers zeroed; out_data value undefined but stable.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, HALT.
- IDLE -> ISSUE when enable=1, gen_ready=1, and level<DEPTH (space reserved for the pending result). Otherwise stay in IDLE.
- ISSUE:
  - gen_go=1 for exactly this cycle; gen_go=0 in every other state.
  - Next state is WAIT_BUSY.
- WAIT_BUSY: wait for gen_ready=0, then go to WAIT_DONE. No ready rising edge is accepted before ready has been seen low.
- WAIT_DONE: on the first cycle with gen_ready=1, sample gen_error and gen_res.
  - gen_error=0: push gen_res, increment count, go to IDLE.
  - gen_error=1: no push, count unchanged, set overflow=1, go to HALT.
- HALT: absorbing state until rst; gen_go stays 0. The FIFO continues to drain normally.
- enable deasserted outside IDLE does not abort the request in flight; it only blocks the next issue.
- Request rate: at most one request outstanding. The minimum issue-to-issue spacing is 4 cycles plus the generator busy time.
- FIFO behaviour:
  - Pop occurs when out_valid and out_ready are both 1.
  - out_data is combinationally the head entry.
  - Push and pop may happen in the same cycle, including at level=DEPTH-1 and at level=1. Level is then unchanged and order is preserved.
  - Push can never hit a full FIFO, because space is reserved at issue. Pop when empty is ignored.
  - Pointers wrap modulo DEPTH.
- count:
  - Wraps modulo 2^CW.
  - Updates in the same cycle as the push; level updates in the same cycle too.
  - Both are registered outputs.
- Reset asserted mid-operation, in any state: immediate clear per the reset values above. Any generator result still in flight is ignored. After reset the block waits in IDLE for gen_ready=1 before issuing again.

Test Plan:
- Reset check: assert rst asynchronously mid-cycle -> gen_go, out_valid, count, level, overflow read 0 before the next clock edge.
- Basic flow:
  - Setup: behavioural primogen model (ready drops one cycle after go, busy 5 cycles, returns 2,3,5,7,11…), out_ready=1, enable=1.
  - Required: out_data stream is 2,3,5,7,11; count=5 after 5 primes; gen_go is never high for 2 consecutive cycles.
- Backpressure:
  - Setup: out_ready=0, DEPTH=8.
  - Required: exactly 8 gen_go pulses, then gen_go stays 0 with level=8 and out_data=2.
  - Then one pop -> exactly one more go, and level returns to 8 with tail=23.
- Overflow:
  - Setup: model asserts gen_error together with the 4th ready rise.
  - Required: overflow=1, count=3, FIFO drains 2,3,5, and no gen_go after entering HALT even with enable=1.
- Simultaneous push/pop and reset:
  - Push/pop: at level=1, a pop coincides with a push -> level stays 1 and order is preserved.
  - Reset: assert rst in WAIT_DONE -> all outputs cleared, the late ready rise causes no push, and a fresh sequence restarts from IDLE.
- Enable gating: drop enable during WAIT_BUSY -> the current result is still pushed, and no further gen_go occurs until enable=1 again.
